// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - shared state encoding and COMP codes for the code-lock controller
package code_lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT1    = 2'd1,
        OPEN_ST = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

endpackage

// File: rtl/meas_cmp.sv
// rtl/meas_cmp.sv - registered unsigned MEAS vs REF comparator, one cycle latency
module meas_cmp
    import code_lock_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] meas,
    input  logic [W-1:0] refv,
    output logic [1:0]   comp
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp <= CMP_EQ;
        end else if (meas == refv) begin
            comp <= CMP_EQ;
        end else if (meas > refv) begin
            comp <= CMP_GT;
        end else begin
            comp <= CMP_LT;
        end
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - two-digit code lock with MEAS/REF interlock, timed OPEN and failure lockout
// Optional GOT1 inter-digit timeout is built when CODE_LOCK_TIMEOUT_EN is defined.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
`ifdef CODE_LOCK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 32
`endif
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] DIGIT,
    input  logic       DIGIT_VLD,
    input  logic [3:0] CODE1,
    input  logic [3:0] CODE2,
    input  logic [3:0] MEAS,
    input  logic [3:0] REF,
    output logic [1:0] COMP,
    output logic       CORR1,
    output logic       CORR2,
    output logic       OPEN,
    output logic       LOCKED,
    output logic [3:0] FAIL_CNT
);

    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t         state;
    logic [TW-1:0]  tmr;
    logic           first_ok;
    logic           accept;
    logic           abort;
    logic           fail_evt;
    logic           last_fail;
    logic           to_hit;

    meas_cmp #(.W(4)) u_meas_cmp (
        .clk   (CLK),
        .rst_n (RST_N),
        .meas  (MEAS),
        .refv  (REF),
        .comp  (COMP)
    );

`ifdef CODE_LOCK_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt;

    // Counter only runs while GOT1 sits idle, so it is zero on every entry to GOT1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt <= '0;
        end else if (state != GOT1 || DIGIT_VLD) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TOW'(1);
        end
    end

    assign to_hit = (state == GOT1) && !DIGIT_VLD && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        first_ok  = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;
        fail_evt  = to_hit;
        last_fail = (({1'b0, FAIL_CNT} + 5'd1) == 5'(MAX_FAIL));
        case (state)
            IDLE: begin
                if (DIGIT_VLD) begin
                    if (DIGIT == CODE1) first_ok = 1'b1;
                    else                fail_evt = 1'b1;
                end
            end
            GOT1: begin
                if (DIGIT_VLD) begin
                    if (DIGIT != CODE2)       fail_evt = 1'b1;
                    else if (COMP == CMP_LT)  abort    = 1'b1;
                    else                      accept   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Timers expire on the cycle they read 1, so each state lasts exactly its parameter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            CORR1    <= 1'b0;
            CORR2    <= 1'b0;
            OPEN     <= 1'b0;
            LOCKED   <= 1'b0;
            FAIL_CNT <= '0;
            tmr      <= '0;
        end else if (first_ok) begin
            CORR1 <= 1'b1;
            state <= GOT1;
        end else if (accept) begin
            CORR2    <= 1'b1;
            OPEN     <= 1'b1;
            tmr      <= TW'(OPEN_CYCLES);
            FAIL_CNT <= '0;
            state    <= OPEN_ST;
        end else if (abort) begin
            CORR1 <= 1'b0;
            state <= IDLE;
        end else if (fail_evt) begin
            CORR1 <= 1'b0;
            CORR2 <= 1'b0;
            if (last_fail) begin
                FAIL_CNT <= 4'(MAX_FAIL);
                LOCKED   <= 1'b1;
                tmr      <= TW'(LOCK_CYCLES);
                state    <= LOCKOUT;
            end else begin
                FAIL_CNT <= FAIL_CNT + 4'd1;
                state    <= IDLE;
            end
        end else if (state == OPEN_ST) begin
            if (tmr == TW'(1)) begin
                OPEN  <= 1'b0;
                CORR1 <= 1'b0;
                CORR2 <= 1'b0;
                tmr   <= '0;
                state <= IDLE;
            end else begin
                tmr <= tmr - TW'(1);
            end
        end else if (state == LOCKOUT) begin
            if (tmr == TW'(1)) begin
                LOCKED   <= 1'b0;
                FAIL_CNT <= '0;
                tmr      <= '0;
                state    <= IDLE;
            end else begin
                tmr <= tmr - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb/tb_code_lock_ctrl.sv - self-checking bench for code_lock_ctrl against a countdown-based model
module tb_code_lock_ctrl;

    localparam int MAXF  = 3;
    localparam int OPENC = 8;
    localparam int LOCKC = 16;
    localparam int TOC   = 32;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit;
    logic       vld;
    logic [3:0] code1;
    logic [3:0] code2;
    logic [3:0] meas;
    logic [3:0] refv;
    logic [1:0] comp;
    logic       corr1;
    logic       corr2;
    logic       open_o;
    logic       locked;
    logic [3:0] fail_cnt;

    int tests = 0;
    int fails = 0;

    code_lock_ctrl #(
        .MAX_FAIL    (MAXF),
        .OPEN_CYCLES (OPENC),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .DIGIT     (digit),
        .DIGIT_VLD (vld),
        .CODE1     (code1),
        .CODE2     (code2),
        .MEAS      (meas),
        .REF       (refv),
        .COMP      (comp),
        .CORR1     (corr1),
        .CORR2     (corr2),
        .OPEN      (open_o),
        .LOCKED    (locked),
        .FAIL_CNT  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining-cycle counters for the open pulse and lockout, a "holding first digit" flag.
    typedef struct packed {
        logic [1:0] comp;
        logic       h1;
        logic [7:0] fails;
        logic [7:0] open_left;
        logic [7:0] lock_left;
        logic [7:0] idle;
    } mstate_t;

    mstate_t m;

    function automatic logic [1:0] cmp_of(input logic [3:0] a, input logic [3:0] b);
        if (a == b) return 2'd0;
        if (a > b)  return 2'd1;
        return 2'd2;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic v, input logic [3:0] d,
                                     input logic [3:0] c1, input logic [3:0] c2,
                                     input logic [3:0] ms, input logic [3:0] rf);
        mstate_t n;
        logic    f;
        n = s;
        f = 1'b0;
        n.comp = cmp_of(ms, rf);
        if (s.open_left != 0) begin
            n.open_left = s.open_left - 8'd1;
            if (n.open_left == 0) n.h1 = 1'b0;
        end else if (s.lock_left != 0) begin
            n.lock_left = s.lock_left - 8'd1;
            if (n.lock_left == 0) n.fails = 8'd0;
        end else if (v) begin
            n.idle = 8'd0;
            if (!s.h1) begin
                if (d == c1) n.h1 = 1'b1;
                else         f = 1'b1;
            end else if (d == c2) begin
                if (s.comp == 2'd2) n.h1 = 1'b0;
                else begin
                    n.open_left = 8'(OPENC);
                    n.fails     = 8'd0;
                end
            end else begin
                f = 1'b1;
            end
        end
`ifdef CODE_LOCK_TIMEOUT_EN
        else if (s.h1) begin
            n.idle = s.idle + 8'd1;
            if (n.idle == 8'(TOC)) f = 1'b1;
        end
`endif
        if (f) begin
            n.h1   = 1'b0;
            n.idle = 8'd0;
            if (s.fails + 8'd1 == 8'(MAXF)) begin
                n.fails     = 8'(MAXF);
                n.lock_left = 8'(LOCKC);
            end else begin
                n.fails = s.fails + 8'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, vld, digit, code1, code2, meas, refv);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_comp",   int'(comp),     int'(m.comp));
            chk("model_corr1",  int'(corr1),    int'(m.h1));
            chk("model_corr2",  int'(corr2),    int'(m.open_left != 0));
            chk("model_open",   int'(open_o),   int'(m.open_left != 0));
            chk("model_locked", int'(locked),   int'(m.lock_left != 0));
            chk("model_fail",   int'(fail_cnt), int'(m.fails));
        end
    end

    task automatic enter(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        vld   = 1'b1;
        @(negedge clk);
        vld   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        digit = 4'd0;
        vld   = 1'b0;
        code1 = 4'd3;
        code2 = 4'd9;
        meas  = 4'd5;
        refv  = 4'd3;
        idle(3);
        chk("rst_comp",   int'(comp),     0);
        chk("rst_corr1",  int'(corr1),    0);
        chk("rst_open",   int'(open_o),   0);
        chk("rst_locked", int'(locked),   0);
        chk("rst_fail",   int'(fail_cnt), 0);
        rst_n = 1'b1;
        idle(2);
        chk("comp_gt", int'(comp), 1);

        // correct entry
        enter(4'd3);
        chk("t1_corr1", int'(corr1), 1);
        chk("t1_corr2_lo", int'(corr2), 0);
        enter(4'd9);
        chk("t1_corr2", int'(corr2), 1);
        cnt = 0;
        while (open_o && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("t1_open_len", cnt, 8);
        chk("t1_corr1_clr", int'(corr1), 0);
        chk("t1_corr2_clr", int'(corr2), 0);
        chk("t1_fail", int'(fail_cnt), 0);

        // interlock abort
        meas = 4'd1;
        idle(2);
        chk("t2_comp_lt", int'(comp), 2);
        enter(4'd3);
        enter(4'd9);
        chk("t2_open", int'(open_o), 0);
        chk("t2_corr1", int'(corr1), 0);
        chk("t2_fail", int'(fail_cnt), 0);

        // lockout, with digits held during lockout
        meas = 4'd5;
        idle(2);
        enter(4'd7);
        chk("t3_fail1", int'(fail_cnt), 1);
        enter(4'd7);
        chk("t3_fail2", int'(fail_cnt), 2);
        enter(4'd7);
        chk("t3_fail3", int'(fail_cnt), 3);
        chk("t3_locked", int'(locked), 1);
        cnt = 0;
        while (locked && cnt < 100) begin
            cnt++;
            digit = 4'd3;
            vld   = 1'b1;
            @(negedge clk);
        end
        vld = 1'b0;
        chk("t3_lock_len", cnt, 16);
        chk("t3_fail_clr", int'(fail_cnt), 0);
        chk("t3_corr1", int'(corr1), 0);

        // wrong second digit, then recovery
        enter(4'd3);
        enter(4'd4);
        chk("t4_corr1", int'(corr1), 0);
        chk("t4_fail", int'(fail_cnt), 1);
        enter(4'd3);
        enter(4'd9);
        chk("t4_open", int'(open_o), 1);
        chk("t4_fail_clr", int'(fail_cnt), 0);
        idle(10);

        // CODE1 repeated in GOT1 is a mismatch
        enter(4'd3);
        enter(4'd3);
        chk("t5_corr1", int'(corr1), 0);
        chk("t5_fail", int'(fail_cnt), 1);

`ifdef CODE_LOCK_TIMEOUT_EN
        enter(4'd3);
        enter(4'd9);
        idle(10);
        enter(4'd3);
        idle(31);
        chk("to_corr1_hold", int'(corr1), 1);
        idle(1);
        chk("to_corr1", int'(corr1), 0);
        chk("to_fail", int'(fail_cnt), 1);
`endif

        // async reset mid-OPEN
        enter(4'd3);
        enter(4'd9);
        idle(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_open",  int'(open_o),   0);
        chk("ar_corr1", int'(corr1),    0);
        chk("ar_corr2", int'(corr2),    0);
        chk("ar_comp",  int'(comp),     0);
        chk("ar_fail",  int'(fail_cnt), 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("ar_comp_back", int'(comp), 1);
        chk("ar_open_idle", int'(open_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
